// File: rtl/shared_ll_fifo_pkg.sv
// rtl/shared_ll_fifo_pkg.sv - shared helpers for the linked-list multi-queue FIFO
// Purpose: width helper functions for PTR_WIDTH / SEL_WIDTH and the ghost-state
//          field layout used when SHARED_LL_FIFO_FORMAL_EN is defined.
// Ports:   none (package).
package shared_ll_fifo_pkg;

    function automatic int clog2_f(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

    function automatic int max_f(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Ghost entry layout is {owner, position}; owner value NUM_FIFOS marks the free list.
    function automatic int free_owner(input int num_fifos);
        return num_fifos;
    endfunction

    function automatic int ghost_owner_width(input int num_fifos);
        return max_f(1, clog2_f(num_fifos + 1));
    endfunction

endpackage

// File: rtl/shared_ll_fifo_free_list.sv
// rtl/shared_ll_fifo_free_list.sv - free-entry list of the shared linked-list store
// Purpose: owns free_head/free_tail/free_count and requests next-pointer writes
//          needed to append released entries to the free list.
// Ports:   clk, rst (sync, active-high); alloc / alloc_next / alloc_ptr hand out
//          the head entry; release_en / release_ptr return an entry;
//          nxt_wr_* is a single write request into the shared next-pointer array;
//          free_count is the number of free entries.
//          With SHARED_LL_FIFO_FORMAL_EN defined, free_tail is also exported.
module ll_free_list
    import shared_ll_fifo_pkg::*;
#(
    parameter int  DEPTH     = 8,
    localparam int PTR_WIDTH = clog2_f(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alloc,
    input  logic [PTR_WIDTH-1:0] alloc_next,
    input  logic                 release_en,
    input  logic [PTR_WIDTH-1:0] release_ptr,
    output logic [PTR_WIDTH-1:0] alloc_ptr,
    output logic [PTR_WIDTH:0]   free_count,
    output logic                 nxt_wr_en,
    output logic [PTR_WIDTH-1:0] nxt_wr_idx,
    output logic [PTR_WIDTH-1:0] nxt_wr_data
`ifdef SHARED_LL_FIFO_FORMAL_EN
    ,
    output logic [PTR_WIDTH-1:0] free_tail
`endif
);

    localparam logic [PTR_WIDTH:0] CNT_ONE = (PTR_WIDTH + 1)'(1);

    logic [PTR_WIDTH-1:0] free_head_q, free_head_d;
    logic [PTR_WIDTH-1:0] free_tail_q, free_tail_d;
    logic [PTR_WIDTH:0]   free_count_q, free_count_d;

    always_comb begin
        free_head_d  = free_head_q;
        free_tail_d  = free_tail_q;
        free_count_d = free_count_q;
        nxt_wr_en    = 1'b0;
        nxt_wr_idx   = free_tail_q;
        nxt_wr_data  = release_ptr;
        case ({alloc, release_en})
            2'b10: begin
                free_head_d  = alloc_next;
                free_count_d = free_count_q - CNT_ONE;
            end
            2'b01: begin
                free_count_d = free_count_q + CNT_ONE;
                free_tail_d  = release_ptr;
                // An empty free list has a stale tail that now belongs to a queue;
                // linking through it would corrupt that queue.
                if (free_count_q == '0) begin
                    free_head_d = release_ptr;
                end else begin
                    nxt_wr_en = 1'b1;
                end
            end
            2'b11: begin
                free_tail_d = release_ptr;
                // Last free entry is being taken: the released entry becomes the whole list.
                if (free_count_q == CNT_ONE) begin
                    free_head_d = release_ptr;
                end else begin
                    free_head_d = alloc_next;
                    nxt_wr_en   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            free_head_q  <= '0;
            free_tail_q  <= PTR_WIDTH'(DEPTH - 1);
            free_count_q <= (PTR_WIDTH + 1)'(DEPTH);
        end else begin
            free_head_q  <= free_head_d;
            free_tail_q  <= free_tail_d;
            free_count_q <= free_count_d;
        end
    end

    assign alloc_ptr  = free_head_q;
    assign free_count = free_count_q;
`ifdef SHARED_LL_FIFO_FORMAL_EN
    assign free_tail  = free_tail_q;
`endif

endmodule

// File: rtl/shared_ll_fifo.sv
// rtl/shared_ll_fifo.sv - NUM_FIFOS linked-list queues sharing one DEPTH-entry store
// Purpose: per-queue head/tail/count, shared data store and next pointers, and the
//          registered pop data path. Illegal pushes/pops are dropped and flagged.
// Ports:   clk, rst (sync, active-high); push/push_sel/data_in enqueue;
//          pop/pop_sel dequeue; data_out/data_out_vld one cycle after an accepted pop;
//          full, empty[q], packed count[q], free_count from registered state;
//          push_err/pop_err registered drop flags.
// Option:  SHARED_LL_FIFO_FORMAL_EN adds ghost ownership tracking and invariant asserts.
module shared_ll_fifo
    import shared_ll_fifo_pkg::*;
#(
    parameter int  WIDTH     = 8,
    parameter int  DEPTH     = 8,
    parameter int  NUM_FIFOS = 4,
    localparam int PTR_WIDTH = clog2_f(DEPTH),
    localparam int SEL_WIDTH = max_f(1, clog2_f(NUM_FIFOS))
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 push,
    input  logic [SEL_WIDTH-1:0]                 push_sel,
    input  logic [WIDTH-1:0]                     data_in,
    input  logic                                 pop,
    input  logic [SEL_WIDTH-1:0]                 pop_sel,
    output logic [WIDTH-1:0]                     data_out,
    output logic                                 data_out_vld,
    output logic                                 full,
    output logic [NUM_FIFOS-1:0]                 empty,
    output logic [NUM_FIFOS*(PTR_WIDTH+1)-1:0]   count,
    output logic [PTR_WIDTH:0]                   free_count,
    output logic                                 push_err,
    output logic                                 pop_err
);

    localparam int              CW      = PTR_WIDTH + 1;
    localparam logic [CW-1:0]   CNT_ONE = CW'(1);

    logic [WIDTH-1:0]     mem_q   [DEPTH];
    logic [WIDTH-1:0]     mem_d   [DEPTH];
    logic [PTR_WIDTH-1:0] nxt_q   [DEPTH];
    logic [PTR_WIDTH-1:0] nxt_d   [DEPTH];
    logic [PTR_WIDTH-1:0] head_q  [NUM_FIFOS];
    logic [PTR_WIDTH-1:0] head_d  [NUM_FIFOS];
    logic [PTR_WIDTH-1:0] tail_q  [NUM_FIFOS];
    logic [PTR_WIDTH-1:0] tail_d  [NUM_FIFOS];
    logic [CW-1:0]        cnt_q   [NUM_FIFOS];
    logic [CW-1:0]        cnt_d   [NUM_FIFOS];

    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             data_out_vld_q, data_out_vld_d;
    logic             push_err_q, push_err_d;
    logic             pop_err_q, pop_err_d;

    logic                 push_ok, pop_ok;
    logic [PTR_WIDTH-1:0] alloc_ptr, pop_slot;
    logic                 fl_wr_en;
    logic [PTR_WIDTH-1:0] fl_wr_idx, fl_wr_data;
`ifdef SHARED_LL_FIFO_FORMAL_EN
    logic [PTR_WIDTH-1:0] free_tail;
`endif

    // Acceptance uses only pre-cycle state.
    assign push_ok  = push && !full && (int'(push_sel) < NUM_FIFOS);
    assign pop_ok   = pop && (int'(pop_sel) < NUM_FIFOS) && (cnt_q[pop_sel] != '0);
    assign pop_slot = head_q[pop_sel];

    ll_free_list #(.DEPTH(DEPTH)) u_free_list (
        .clk         (clk),
        .rst         (rst),
        .alloc       (push_ok),
        .alloc_next  (nxt_q[alloc_ptr]),
        .release_en  (pop_ok),
        .release_ptr (pop_slot),
        .alloc_ptr   (alloc_ptr),
        .free_count  (free_count),
        .nxt_wr_en   (fl_wr_en),
        .nxt_wr_idx  (fl_wr_idx),
        .nxt_wr_data (fl_wr_data)
`ifdef SHARED_LL_FIFO_FORMAL_EN
        ,
        .free_tail   (free_tail)
`endif
    );

    always_comb begin
        mem_d          = mem_q;
        nxt_d          = nxt_q;
        head_d         = head_q;
        tail_d         = tail_q;
        cnt_d          = cnt_q;
        data_out_d     = data_out_q;
        data_out_vld_d = pop_ok;
        push_err_d     = push && !push_ok;
        pop_err_d      = pop && !pop_ok;

        if (pop_ok) begin
            data_out_d      = mem_q[pop_slot];
            head_d[pop_sel] = nxt_q[pop_slot];
            cnt_d[pop_sel]  = cnt_q[pop_sel] - CNT_ONE;
        end

        // cnt_d already reflects a same-cycle pop, so a queue drained by that pop
        // restarts at the pushed entry instead of linking behind a freed tail.
        if (push_ok) begin
            mem_d[alloc_ptr]  = data_in;
            tail_d[push_sel]  = alloc_ptr;
            if (cnt_d[push_sel] == '0) begin
                head_d[push_sel] = alloc_ptr;
            end else begin
                nxt_d[tail_q[push_sel]] = alloc_ptr;
            end
            cnt_d[push_sel] = cnt_d[push_sel] + CNT_ONE;
        end

        // Queue tail and free-list tail are never the same entry, so both writes coexist.
        if (fl_wr_en) begin
            nxt_d[fl_wr_idx] = fl_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                nxt_q[i] <= PTR_WIDTH'((i + 1) % DEPTH);
            end
            for (int q = 0; q < NUM_FIFOS; q++) begin
                head_q[q] <= '0;
                tail_q[q] <= '0;
                cnt_q[q]  <= '0;
            end
            data_out_q     <= '0;
            data_out_vld_q <= 1'b0;
            push_err_q     <= 1'b0;
            pop_err_q      <= 1'b0;
        end else begin
            nxt_q          <= nxt_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            cnt_q          <= cnt_d;
            data_out_q     <= data_out_d;
            data_out_vld_q <= data_out_vld_d;
            push_err_q     <= push_err_d;
            pop_err_q      <= pop_err_d;
        end
    end

    always_comb begin
        count = '0;
        empty = '0;
        for (int q = 0; q < NUM_FIFOS; q++) begin
            count[q*CW +: CW] = cnt_q[q];
            empty[q]          = (cnt_q[q] == '0);
        end
    end

    assign full         = (free_count == '0);
    assign data_out     = data_out_q;
    assign data_out_vld = data_out_vld_q;
    assign push_err     = push_err_q;
    assign pop_err      = pop_err_q;

`ifdef SHARED_LL_FIFO_FORMAL_EN
    localparam int OW = ghost_owner_width(NUM_FIFOS);

    logic [OW-1:0]        g_owner [DEPTH];
    logic [PTR_WIDTH-1:0] g_pos   [DEPTH];
    logic [DEPTH-1:0]     g_seen;
    logic [PTR_WIDTH-1:0] g_cur;
    logic                 g_dup, g_queue_ok, g_free_ok, g_sum_ok;
    logic [PTR_WIDTH-1:0] ghost_sel_q;
    int                   g_sum;

    (* keep *) logic [PTR_WIDTH-1:0]    ghost_sel;
    (* keep *) logic [OW+PTR_WIDTH-1:0] ghost_result;

    // Walk every list from its head, tagging each visited entry with its owner
    // and position; a revisit means two owners claim the entry.
    always_comb begin
        g_seen     = '0;
        g_dup      = 1'b0;
        g_queue_ok = 1'b1;
        g_free_ok  = 1'b1;
        g_cur      = '0;
        g_sum      = int'(free_count);
        for (int i = 0; i < DEPTH; i++) begin
            g_owner[i] = OW'(free_owner(NUM_FIFOS));
            g_pos[i]   = '0;
        end
        for (int q = 0; q < NUM_FIFOS; q++) begin
            g_sum = g_sum + int'(cnt_q[q]);
            g_cur = head_q[q];
            for (int k = 0; k < DEPTH; k++) begin
                if (k < int'(cnt_q[q])) begin
                    if (g_seen[g_cur]) g_dup = 1'b1;
                    g_seen[g_cur]  = 1'b1;
                    g_owner[g_cur] = OW'(q);
                    g_pos[g_cur]   = PTR_WIDTH'(k);
                    if ((k == int'(cnt_q[q]) - 1) && (g_cur != tail_q[q])) g_queue_ok = 1'b0;
                    g_cur = nxt_q[g_cur];
                end
            end
        end
        g_cur = alloc_ptr;
        for (int k = 0; k < DEPTH; k++) begin
            if (k < int'(free_count)) begin
                if (g_seen[g_cur]) g_dup = 1'b1;
                g_seen[g_cur] = 1'b1;
                g_pos[g_cur]  = PTR_WIDTH'(k);
                if ((k == int'(free_count) - 1) && (g_cur != free_tail)) g_free_ok = 1'b0;
                g_cur = nxt_q[g_cur];
            end
        end
        g_sum_ok = (g_sum == DEPTH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ghost_sel_q <= '0;
        end else begin
            ghost_sel_q <= ghost_sel_q + PTR_WIDTH'(1);
            assert (g_free_ok);
            assert (g_queue_ok);
            assert (!g_dup);
            assert (g_sum_ok);
        end
    end

    assign ghost_sel    = ghost_sel_q;
    assign ghost_result = {g_owner[ghost_sel], g_pos[ghost_sel]};
`endif

endmodule

// File: doc/shared_ll_fifo.md
# shared_ll_fifo

Multi-queue FIFO with NUM_FIFOS logical queues sharing one DEPTH-entry data store. Queues are singly linked lists threaded through a common next-pointer array; unused entries form a free list. Any queue may use any free entry. Illegal pushes and pops are dropped and flagged rather than left to the environment. Feeds the linked-list refinement-proof harness and is instantiated directly by arbitration/egress logic.

## Interface
- WIDTH, 8, data bits per entry
- DEPTH, 8, total shared entries; power of two, ≥2
- NUM_FIFOS, 4, logical queues, ≥1
- PTR_WIDTH, $clog2(DEPTH), entry index width (derived)
- SEL_WIDTH, max(1,$clog2(NUM_FIFOS)), queue select width (derived)
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high; clock is clk
- push  in  1  enqueue request
- push_sel  in  SEL_WIDTH  target queue for push
- data_in  in  WIDTH  push data
- pop  in  1  dequeue request
- pop_sel  in  SEL_WIDTH  source queue for pop
- data_out  out  WIDTH  popped data, registered
- data_out_vld  out  1  data_out holds data from an accepted pop of the previous cycle
- full  out  1  free_count == 0
- empty  out  NUM_FIFOS  bit q set when count[q] == 0
- count  out  NUM_FIFOS*(PTR_WIDTH+1)  packed per-queue occupancy; queue q is at bits [q*(PTR_WIDTH+1) +: PTR_WIDTH+1]
- free_count  out  PTR_WIDTH+1  free entries
- push_err  out  1  registered; push was dropped in the previous cycle
- pop_err  out  1  registered; pop was dropped in the previous cycle

## Operation
- State:
  - mem[DEPTH] for data.
  - nxt[DEPTH] for next pointers.
  - head[q], tail[q], count[q] per queue.
  - free_head, free_tail, free_count.
- Reset:
  - nxt[i] = i+1 mod DEPTH; free_head = 0; free_tail = DEPTH-1; free_count = DEPTH.
  - Every count[q] = 0; head and tail = 0.
  - Outputs: data_out = 0; data_out_vld = push_err = pop_err = 0; full = 0; empty = all ones.
- Push acceptance: push_ok = push & ~full & (push_sel < NUM_FIFOS). The check uses pre-cycle state, so a push is rejected when full even if a pop frees an entry in the same cycle.
- Pop acceptance: pop_ok = pop & (pop_sel < NUM_FIFOS) & ~empty[pop_sel], using pre-cycle count. A same-cycle push to an empty queue does not make a pop legal.
- Rejected requests change no state and raise the matching err bit for one cycle.
- Accepted push, slot s = free_head:
  - mem[s] <= data_in; tail[q] <= s; free_head <= nxt[s].
  - If count[q] == 0 (after any same-cycle pop), head[q] <= s; otherwise nxt[tail[q]] <= s.
- Accepted pop, slot p = head[q]:
  - data_out <= mem[p]; data_out_vld <= 1; head[q] <= nxt[p].
  - p is appended to the free list: nxt[free_tail] <= p; free_tail <= p.
- Simultaneous push and pop:
  - Same queue with count == 1: the queue becomes the single pushed entry; head = tail = s.
  - Push takes the last free entry while a pop returns p: free_head <= p; free_tail <= p.
  - free_count == 0 is impossible here, because push is rejected when full.
  - Otherwise push and pop update disjoint pointers independently.
- Arithmetic:
  - count[q] <= count[q] + push_ok(q) - pop_ok(q).
  - free_count <= free_count - push_ok + pop_ok.
  - All values are PTR_WIDTH+1 bits with no wrap.
  - Invariant: sum of count[q] + free_count == DEPTH.

## Timing
- All state updates on posedge clk.
- full, empty, count and free_count are combinational from registers and reflect state after the last edge.
- Pop latency is 1 cycle: data_out and data_out_vld are valid the cycle after the accepted pop. data_out_vld is low on any cycle without an accepted pop; data_out holds its last value.
- Push-to-pop latency is 1 cycle: data pushed at edge n can be popped in cycle n+1.
- Reset mid-operation discards all queued data; outputs take reset values at the next edge.

## Configuration
- SHARED_LL_FIFO_FORMAL_EN
- Defined:
  - Embeds ghost position tracking: per entry, {owner queue or free, position in list}.
  - Asserts every cycle:
    - the free-list walk from free_head reaches free_tail in free_count-1 steps;
    - the walk of each queue from head[q] covers count[q] entries;
    - no entry has two owners;
    - sum invariant holds.
  - Exposes ghost_sel/ghost_result on a (* keep *) wire for CoSA/Jasper.
- Undefined: no ghost logic and no assertions. Ports and functional behaviour are identical.

## Structure
- Package shared_ll_fifo_pkg holds:
  - the clog2/max helper functions for PTR_WIDTH/SEL_WIDTH;
  - ghost-state field layout constants: FREE_OWNER encoding = NUM_FIFOS.
- Sub-module ll_free_list owns free_head, free_tail, free_count and nxt writes for frees. Interface: alloc, release, release_ptr, alloc_ptr, free_count.
- The top block owns per-queue pointers, mem and the data_out register.

## Test plan
All cases use WIDTH=8, DEPTH=4, NUM_FIFOS=2.
- Reset, then push 0x11,0x22 to q0 and 0x33 to q1 -> count q0=2, q1=1; free_count=1; empty=2'b00.
- Pop q0 twice -> data_out 0x11 then 0x22, each with data_out_vld one cycle after its pop; empty[0]=1.
- Fill all 4 entries, push q1 again -> push_err=1 next cycle; counts and free_count unchanged.
- full; in the same cycle pop q0 and push 0x44 to q1 -> push dropped with push_err=1; pop accepted; free_count=1.
- q0 holds one entry (0x55); in the same cycle push 0x66 to q0 and pop q0 -> data_out=0x55; count q0=1; next pop returns 0x66.
- Pop empty q1 while pushing 0x77 to q1 -> pop_err=1; count q1=1; data_out_vld=0.
